// File: rtl/md_unit_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
package md_unit_pkg;

    localparam int ITER_CYCLES = 32;
    localparam int CNT_W       = $clog2(ITER_CYCLES) + 1;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/md_if.sv
// Decode-side bundle for the multiply/divide unit: operation request, HI/LO access and hazard status.
interface md_if;

    logic        Start;
    logic [1:0]  Md_op;
    logic [31:0] Read_data_1;
    logic [31:0] Read_data_2;
    logic        Read_hi;
    logic        Read_lo;
    logic        Write_hi;
    logic        Write_lo;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic        Divide_zero;

    modport master (
        output Start, Md_op, Read_data_1, Read_data_2,
        output Read_hi, Read_lo, Write_hi, Write_lo,
        input  Hi, Lo, Busy, Stall, Done, Divide_zero
    );

    modport slave (
        input  Start, Md_op, Read_data_1, Read_data_2,
        input  Read_hi, Read_lo, Write_hi, Write_lo,
        output Hi, Lo, Busy, Stall, Done, Divide_zero
    );

endinterface

// File: rtl/md_iter_core.sv
// Unsigned iterative datapath: one shift-add (multiply) or restore-subtract (divide) step per cycle.
module md_iter_core
    import md_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        init,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] init_val,
    input  logic [31:0] addend,
    output logic [63:0] acc,
    output logic        last
);

    logic [CNT_W-1:0] count;
    logic [32:0]      sum;
    logic [32:0]      rem;
    logic [32:0]      diff;
    logic             q_bit;
    logic [31:0]      hi_next;

    // acc[63:32] is the running product high half / partial remainder,
    // acc[31:0] shifts out multiplier bits (LSB first) or dividend bits (MSB first).
    always_comb begin
        sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, addend} : 33'd0);
        rem     = {acc[63:32], acc[31]};
        diff    = rem - {1'b0, addend};
        q_bit   = (rem >= {1'b0, addend});
        hi_next = q_bit ? diff[31:0] : rem[31:0];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc   <= '0;
            count <= '0;
        end else if (init) begin
            acc   <= {32'h0, init_val};
            count <= '0;
        end else if (step) begin
            acc   <= is_div ? {hi_next, acc[30:0], q_bit} : {sum, acc[31:1]};
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(ITER_CYCLES - 1));

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: sequencing FSM, sign handling, HI/LO registers and pipeline hazard outputs.
//   state   | meaning
//   IDLE    | no operation in flight; HI/LO writable, Start accepted
//   CALC    | one datapath iteration per cycle on operand magnitudes
//   FIX     | apply result signs and commit HI/LO
module md_unit
    import md_unit_pkg::*;
(
    input logic clock,
    input logic reset,
    md_if.slave md
);

    md_state_e   state;
    md_state_e   state_next;
    md_op_e      op_in;
    logic        accept;
    logic        step;
    logic        last;
    logic        divide_zero;
    logic        busy;
    logic        in_is_div;
    logic        in_sign_a;
    logic        in_sign_b;
    logic [31:0] in_mag_a;
    logic [31:0] in_mag_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        sign_a;
    logic        sign_b;
    logic        is_div_q;
    logic [63:0] acc;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;
    logic        op_signed;

    assign op_in     = md_op_e'(md.Md_op);
    assign in_is_div = (op_in == MD_DIV) || (op_in == MD_DIVU);
    assign op_signed = (op_in == MD_MULT) || (op_in == MD_DIV);
    assign in_sign_a = op_signed & md.Read_data_1[31];
    assign in_sign_b = op_signed & md.Read_data_2[31];
    assign in_mag_a  = in_sign_a ? -md.Read_data_1 : md.Read_data_1;
    assign in_mag_b  = in_sign_b ? -md.Read_data_2 : md.Read_data_2;

    assign busy        = (state != ST_IDLE);
    assign divide_zero = md.Start & in_is_div & (md.Read_data_2 == 32'h0) & (state == ST_IDLE);

    always_ff @(posedge clock) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: if (md.Start && !divide_zero) begin
                accept     = 1'b1;
                state_next = ST_CALC;
            end
            ST_CALC: begin
                step = 1'b1;
                if (last) state_next = ST_FIX;
            end
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Multiply: multiplier (rt) shifts through the low half, multiplicand (rs) is added.
    // Divide: dividend (rs) shifts through the low half, divisor (rt) is subtracted.
    md_iter_core u_core (
        .clock    (clock),
        .reset    (reset),
        .init     (accept),
        .step     (step),
        .is_div   (is_div_q),
        .init_val (in_is_div ? in_mag_a : in_mag_b),
        .addend   (is_div_q ? mag_b : mag_a),
        .acc      (acc),
        .last     (last)
    );

    // Remainder follows the dividend sign, quotient/product the sign product.
    always_comb begin
        prod = (sign_a ^ sign_b) ? -acc : acc;
        quo  = (sign_a ^ sign_b) ? -acc[31:0] : acc[31:0];
        rem  = sign_a ? -acc[63:32] : acc[63:32];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            done_q <= (state == ST_FIX);
            if (accept) begin
                mag_a    <= in_mag_a;
                mag_b    <= in_mag_b;
                sign_a   <= in_sign_a;
                sign_b   <= in_sign_b;
                is_div_q <= in_is_div;
            end else if (state == ST_FIX) begin
                hi_q <= is_div_q ? rem : prod[63:32];
                lo_q <= is_div_q ? quo : prod[31:0];
            end else if (state == ST_IDLE && !md.Start) begin
                if (md.Write_hi) hi_q <= md.Read_data_1;
                if (md.Write_lo) lo_q <= md.Read_data_1;
            end
        end
    end

    assign md.Hi          = hi_q;
    assign md.Lo          = lo_q;
    assign md.Busy        = busy;
    assign md.Done        = done_q;
    assign md.Divide_zero = divide_zero;
    assign md.Stall       = busy & (md.Start | md.Read_hi | md.Read_lo | md.Write_hi | md.Write_lo);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized traffic against a 64-bit arithmetic model.
module tb_md_unit;
    import md_unit_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    md_if md();

    md_unit dut (
        .clock (clock),
        .reset (reset),
        .md    (md)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic        model_valid = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    int          m_cnt = 0;
    logic        m_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {HI, LO} computed with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        r  = '0;
        case (op)
            MD_MULT:  r = sa * sb;
            MD_MULTU: r = ua * ub;
            MD_DIV: begin
                sq = sa / sb;
                sr = sa % sb;
                r  = {sr[31:0], sq[31:0]};
            end
            default: begin
                uq = ua / ub;
                ur = ua % ub;
                r  = {ur[31:0], uq[31:0]};
            end
        endcase
        return r;
    endfunction

    // Model update: an accepted op commits 33 edges later.
    always @(posedge clock) begin
        logic [63:0] r;
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_cnt = 0; m_done = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            m_done = 1'b0;
            if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end else if (md.Start) begin
                if (!(md.Md_op[1] && md.Read_data_2 == 32'h0)) begin
                    r = ref_result(md.Md_op, md.Read_data_1, md.Read_data_2);
                    p_hi = r[63:32];
                    p_lo = r[31:0];
                    m_cnt = ITER_CYCLES + 1;
                end
            end else begin
                if (md.Write_hi) m_hi = md.Read_data_1;
                if (md.Write_lo) m_lo = md.Read_data_1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        logic busy, any_hz;
        if (model_valid) begin
            busy   = (m_cnt != 0);
            any_hz = md.Start | md.Read_hi | md.Read_lo | md.Write_hi | md.Write_lo;
            chk("Hi", md.Hi, m_hi);
            chk("Lo", md.Lo, m_lo);
            chk("Busy", md.Busy, busy);
            chk("Done", md.Done, m_done);
            chk("Stall", md.Stall, busy & any_hz);
            chk("Divide_zero", md.Divide_zero,
                md.Start & md.Md_op[1] & (md.Read_data_2 == 32'h0) & !busy);
        end
    end

    task automatic idle_inputs();
        md.Start = 1'b0; md.Md_op = 2'b00;
        md.Read_data_1 = '0; md.Read_data_2 = '0;
        md.Read_hi = 1'b0; md.Read_lo = 1'b0; md.Write_hi = 1'b0; md.Write_lo = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        @(posedge clock); #2;
        md.Start = 1'b1; md.Md_op = op; md.Read_data_1 = a; md.Read_data_2 = b;
        @(posedge clock); #2;
        md.Start = 1'b0;
        n = 0;
        while (md.Busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clock); #2;
        end
        chk({name, " busy cycles"}, 64'(n), 64'd33);
        chk({name, " done"}, md.Done, 1'b1);
        chk({name, " hi"}, md.Hi, eh);
        chk({name, " lo"}, md.Lo, el);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
        return $urandom;
    endfunction

    initial begin
        int n;
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        chk("reset hi", md.Hi, 32'h0);
        chk("reset lo", md.Lo, 32'h0);
        chk("reset busy", md.Busy, 1'b0);

        // Pin the model against hand-computed values.
        chk("model mult", ref_result(MD_MULT, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        chk("model div ovf", ref_result(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        chk("model divu", ref_result(MD_DIVU, 32'd7, 32'd2), 64'h0000_0001_0000_0003);

        run_op("mult -3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 7/2", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        run_op("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // Divide by zero: flagged combinationally, nothing starts, HI/LO untouched.
        @(posedge clock); #2;
        md.Start = 1'b1; md.Md_op = MD_DIVU; md.Read_data_1 = 32'h8000_0000; md.Read_data_2 = 32'h0;
        #1 chk("divzero flag", md.Divide_zero, 1'b1);
        @(posedge clock); #2;
        md.Start = 1'b0;
        chk("divzero busy", md.Busy, 1'b0);
        chk("divzero hi", md.Hi, 32'h0);
        chk("divzero lo", md.Lo, 32'h8000_0000);

        // mthi then mult with mflo waiting on the result.
        @(posedge clock); #2;
        md.Write_hi = 1'b1; md.Read_data_1 = 32'h1234;
        @(posedge clock); #2;
        md.Write_hi = 1'b0;
        chk("mthi", md.Hi, 32'h1234);
        md.Start = 1'b1; md.Md_op = MD_MULT; md.Read_data_1 = 32'd2; md.Read_data_2 = 32'd3;
        @(posedge clock); #2;
        md.Start = 1'b0; md.Read_lo = 1'b1;
        n = 0;
        while (md.Stall === 1'b1 && n < 40) begin
            n++;
            @(posedge clock); #2;
        end
        chk("mflo stall cycles", 64'(n), 64'd33);
        chk("mflo done", md.Done, 1'b1);
        chk("mflo lo", md.Lo, 32'd6);
        chk("mflo hi", md.Hi, 32'h0);
        md.Read_lo = 1'b0;

        // Reset mid-operation aborts and clears.
        @(posedge clock); #2;
        md.Start = 1'b1; md.Md_op = MD_MULTU; md.Read_data_1 = 32'd9; md.Read_data_2 = 32'd9;
        @(posedge clock); #2;
        md.Start = 1'b0;
        repeat (9) @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock); #2;
        reset = 1'b1;
        chk("abort busy", md.Busy, 1'b0);
        chk("abort hi", md.Hi, 32'h0);
        chk("abort lo", md.Lo, 32'h0);
        run_op("post-abort divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // Randomized traffic, including ops started in the Done cycle and requests while busy.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clock); #2;
            reset          = ($urandom_range(999) != 0);
            md.Start       = ($urandom_range(2) == 0);
            md.Md_op       = 2'($urandom_range(3));
            md.Read_data_1 = pick_operand();
            md.Read_data_2 = ($urandom_range(7) == 0) ? 32'h0 : pick_operand();
            md.Read_hi     = ($urandom_range(7) == 0);
            md.Read_lo     = ($urandom_range(7) == 0);
            md.Write_hi    = ($urandom_range(7) == 0);
            md.Write_lo    = ($urandom_range(7) == 0);
        end

        @(posedge clock); #2;
        reset = 1'b1;
        idle_inputs();
        repeat (40) @(posedge clock);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
